// File: rtl/timer_pkg.sv
// Shared constants and helpers for the multi-channel timer.
// No logic or latency of its own; no backpressure.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Terminal value a channel wakes up with: all ones, so an unprogrammed
  // one-shot channel saturates at the top of its range.
  function automatic logic [63:0] default_term(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Control/status bundle between a timer_multi and whatever drives it.
// Pure wiring, zero latency; no backpressure (all signals are levels or pulses).
interface timer_multi_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       START;
  logic [CHANNELS-1:0]       CLEAR;
  logic [CHANNELS-1:0]       LOAD;
  logic [CHANNELS*WIDTH-1:0] LOAD_VAL;
  logic [CHANNELS-1:0]       MODE;
  logic [CHANNELS*WIDTH-1:0] COUNT;
  logic [CHANNELS-1:0]       DONE;
  logic [CHANNELS-1:0]       EXPIRE;
  logic [CHANNELS-1:0]       RST_OK;
  logic                      TICK;

  modport master (
    output START, CLEAR, LOAD, LOAD_VAL, MODE,
    input  COUNT, DONE, EXPIRE, RST_OK, TICK
  );

  modport slave (
    input  START, CLEAR, LOAD, LOAD_VAL, MODE,
    output COUNT, DONE, EXPIRE, RST_OK, TICK
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: programmable terminal, one-shot or periodic, DONE/EXPIRE/RST_OK.
// COUNT/EXPIRE/RST_OK update one cycle after the qualifying tick, DONE is combinational; no backpressure.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             clear,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             expire,
  output logic             rst_ok
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] count_inc;
  logic             expire_q;
  logic             rst_ok_q;
  logic             below;

  assign count_inc = count_q + WIDTH'(1);
  assign below     = (count_q < term_q);

  // EXPIRE defaults low every cycle so it can never stretch past one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      term_q   <= WIDTH'(default_term(WIDTH));
      expire_q <= 1'b0;
      rst_ok_q <= 1'b1;
    end else begin
      expire_q <= 1'b0;
      if (clear) begin
        count_q  <= '0;
        rst_ok_q <= 1'b1;
      end else if (load) begin
        term_q <= load_val;
      end else if (start && tick) begin
        if (below) begin
          count_q  <= count_inc;
          rst_ok_q <= 1'b0;
          expire_q <= (count_inc == term_q);
        end else if (mode == MODE_PERIODIC) begin
          count_q  <= '0;
          expire_q <= (term_q == '0);
        end
      end
    end
  end

  assign count  = count_q;
  assign expire = expire_q;
  assign rst_ok = rst_ok_q;
  assign done   = start & ~clear & ~below;

endmodule

// File: rtl/timer_multi.sv
// N independent timer channels sharing one free-running prescaler on clk_2K.
// Channel outputs follow the qualifying tick by one cycle, DONE is combinational; no backpressure.
module timer_multi
  import timer_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic          clk_2K,
  input  logic          RESET_N,
  timer_multi_if.slave  bus
);

  localparam int             PW         = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_nxt;
  logic          tick_q;

  assign presc_nxt = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);

  // TICK is registered so it reads 0 while in reset, yet lines up with the
  // cycle in which the prescaler holds its last value.
  always_ff @(posedge clk_2K or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_nxt;
      tick_q  <= (presc_nxt == PRESC_LAST);
    end
  end

  logic [CHANNELS*WIDTH-1:0] count_w;
  logic [CHANNELS-1:0]       done_w;
  logic [CHANNELS-1:0]       expire_w;
  logic [CHANNELS-1:0]       rst_ok_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk_2K),
      .rst_n    (RESET_N),
      .tick     (tick_q),
      .start    (bus.START[i]),
      .clear    (bus.CLEAR[i]),
      .load     (bus.LOAD[i]),
      .mode     (bus.MODE[i]),
      .load_val (bus.LOAD_VAL[i*WIDTH +: WIDTH]),
      .count    (count_w[i*WIDTH +: WIDTH]),
      .done     (done_w[i]),
      .expire   (expire_w[i]),
      .rst_ok   (rst_ok_w[i])
    );
  end

  assign bus.COUNT  = count_w;
  assign bus.DONE   = done_w;
  assign bus.EXPIRE = expire_w;
  assign bus.RST_OK = rst_ok_w;
  assign bus.TICK   = tick_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: PRESCALE=1 instance (dut_a) and PRESCALE=4 instance (dut_b).
// Expected channel states are queued when stimulus is driven and popped after the clock edge.
module tb_timer_multi;

  localparam int W = 12;
  localparam int N = 4;

  logic clk_2K = 1'b0;
  logic rst_n;
  always #5 clk_2K = ~clk_2K;

  timer_multi_if #(.WIDTH(W), .CHANNELS(N)) ifa ();
  timer_multi_if #(.WIDTH(W), .CHANNELS(N)) ifb ();

  timer_multi #(.WIDTH(W), .CHANNELS(N), .PRESCALE(1)) dut_a (
    .clk_2K  (clk_2K),
    .RESET_N (rst_n),
    .bus     (ifa)
  );

  timer_multi #(.WIDTH(W), .CHANNELS(N), .PRESCALE(4)) dut_b (
    .clk_2K  (clk_2K),
    .RESET_N (rst_n),
    .bus     (ifb)
  );

  typedef struct {
    string        tag;
    bit           on_b;
    int           ch;
    logic [W-1:0] cnt;
    logic         done;
    logic         expire;
    logic         rok;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_ch(input string tag, input bit on_b, input int ch, input int cnt,
                           input logic done, input logic expire, input logic rok);
    exp_t e;
    e.tag = tag; e.on_b = on_b; e.ch = ch; e.cnt = W'(cnt);
    e.done = done; e.expire = expire; e.rok = rok;
    sb.push_back(e);
  endtask

  task automatic expect_reset_all(input string tag);
    for (int c = 0; c < N; c++) begin
      expect_ch(tag, 1'b0, c, 0, 1'b0, 1'b0, 1'b1);
      expect_ch(tag, 1'b1, c, 0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      logic [W+2:0] obs;
      logic [W+2:0] want;
      e = sb.pop_front();
      if (e.on_b)
        obs = {ifb.COUNT[e.ch*W +: W], ifb.DONE[e.ch], ifb.EXPIRE[e.ch], ifb.RST_OK[e.ch]};
      else
        obs = {ifa.COUNT[e.ch*W +: W], ifa.DONE[e.ch], ifa.EXPIRE[e.ch], ifa.RST_OK[e.ch]};
      want = {e.cnt, e.done, e.expire, e.rok};
      checks++;
      assert (obs === want) else begin
        failures++;
        $error("FAIL %s dut_%s ch%0d {count,done,expire,rst_ok} observed=%h expected=%h",
               e.tag, e.on_b ? "b" : "a", e.ch, obs, want);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk_2K);
    #1;
    drain();
  endtask

  initial begin
    int pulses;
    int n;
    int k;
    int c;

    rst_n        = 1'b0;
    ifa.START    = '0; ifa.CLEAR = '0; ifa.LOAD = '0; ifa.LOAD_VAL = '0; ifa.MODE = '0;
    ifb.START    = '0; ifb.CLEAR = '0; ifb.LOAD = '0; ifb.LOAD_VAL = '0; ifb.MODE = '0;

    // Reset and idle
    #23;
    expect_reset_all("in_reset");
    drain();
    check_bit("tick_a_in_reset", ifa.TICK, 1'b0);
    check_bit("tick_b_in_reset", ifb.TICK, 1'b0);
    @(posedge clk_2K);
    #3 rst_n = 1'b1;
    expect_reset_all("idle");
    step();
    step();
    check_bit("tick_a_prescale1", ifa.TICK, 1'b1);

    // One-shot, terminal 5, on dut_a ch0
    ifa.LOAD[0] = 1'b1;
    ifa.LOAD_VAL[0*W +: W] = W'(5);
    expect_ch("oneshot_load", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step();
    ifa.LOAD[0]  = 1'b0;
    ifa.START[0] = 1'b1;
    for (k = 1; k <= 7; k++) begin
      c = (k > 5) ? 5 : k;
      expect_ch("oneshot_run", 1'b0, 0, c, c == 5, k == 5, 1'b0);
      if (k == 7) expect_ch("oneshot_iso", 1'b0, 1, 0, 1'b0, 1'b0, 1'b1);
      step();
    end

    // Default terminal saturation on dut_a ch2
    ifa.START[2] = 1'b1;
    pulses = 0;
    repeat (4100) begin
      @(posedge clk_2K);
      #1;
      if (ifa.EXPIRE[2] === 1'b1) pulses++;
    end
    expect_ch("saturate", 1'b0, 2, 4095, 1'b1, 1'b0, 1'b0);
    drain();
    checks++;
    assert (pulses == 1) else begin
      failures++;
      $error("FAIL saturate_pulses observed=%0d expected=1", pulses);
    end

    // CLEAR beats LOAD beats counting on dut_a ch3
    ifa.START[3] = 1'b1;
    expect_ch("prio_pre", 1'b0, 3, 1, 1'b0, 1'b0, 1'b0);
    step();
    expect_ch("prio_pre", 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);
    step();
    ifa.CLEAR[3] = 1'b1;
    ifa.LOAD[3]  = 1'b1;
    ifa.LOAD_VAL[3*W +: W] = W'(7);
    check_bit("prio_tick", ifa.TICK, 1'b1);
    expect_ch("prio_collide", 1'b0, 3, 0, 1'b0, 1'b0, 1'b1);
    step();
    ifa.CLEAR[3] = 1'b0;
    ifa.LOAD[3]  = 1'b0;
    for (k = 1; k <= 9; k++) begin
      expect_ch("prio_term_kept", 1'b0, 3, k, 1'b0, 1'b0, 1'b0);
      step();
    end
    ifa.START[3] = 1'b0;

    // Periodic, terminal 2, PRESCALE=4, on dut_b ch1
    ifb.MODE[1] = 1'b1;
    ifb.LOAD[1] = 1'b1;
    ifb.LOAD_VAL[1*W +: W] = W'(2);
    expect_ch("periodic_load", 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    step();
    ifb.LOAD[1] = 1'b0;
    n = 0;
    while (ifb.TICK !== 1'b1 && n < 8) begin
      @(posedge clk_2K);
      #1;
      n++;
    end
    check_bit("periodic_tick_found", ifb.TICK, 1'b1);
    ifb.START[1] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      k = (e - 1) / 4;
      c = (k + 1) % 3;
      expect_ch("periodic_run", 1'b1, 1, c, c == 2, ((e - 1) % 4 == 0) && (k % 3 == 1), 1'b0);
      step();
    end

    // Mid-run asynchronous reset on dut_a
    ifa.START = '0;
    ifa.CLEAR = 4'b0011;
    expect_ch("mid_clear", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    expect_ch("mid_clear", 1'b0, 1, 0, 1'b0, 1'b0, 1'b1);
    step();
    ifa.CLEAR = '0;
    ifa.LOAD  = 4'b0001;
    ifa.LOAD_VAL[0*W +: W] = W'(10);
    expect_ch("mid_load", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step();
    ifa.LOAD  = '0;
    ifa.START = 4'b0011;
    for (k = 1; k <= 3; k++) begin
      expect_ch("mid_run", 1'b0, 0, k, 1'b0, 1'b0, 1'b0);
      expect_ch("mid_run", 1'b0, 1, k, 1'b0, 1'b0, 1'b0);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    expect_reset_all("async_reset");
    drain();
    check_bit("async_reset_tick_a", ifa.TICK, 1'b0);
    check_bit("async_reset_tick_b", ifb.TICK, 1'b0);
    #4 rst_n = 1'b1;
    expect_ch("post_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    expect_ch("post_reset", 1'b0, 1, 0, 1'b0, 1'b0, 1'b1);
    step();

    // CLEAR toggling on ch0 leaves ch1 counting untouched
    for (k = 1; k <= 6; k++) begin
      ifa.CLEAR[0] = (k % 2 == 1);
      if (k % 2 == 1)
        expect_ch("iso_ch0", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      else
        expect_ch("iso_ch0", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
      expect_ch("iso_ch1", 1'b0, 1, k, 1'b0, 1'b0, 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
